// File: rtl/hrv_pkg.sv
// Shared types and default constants for the HRV front-end sequencer.
package hrv_pkg;

  localparam int HRV_CNT_W      = 12;
  localparam int HRV_FIFO_DEPTH = 4;
  localparam int HRV_MIN_RR     = 250;
  localparam int HRV_MAX_RR     = 2000;

  // Interval FSM states; encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } rr_state_t;

endpackage

// File: rtl/hrv_rr_fifo.sv
// First-word fall-through FIFO holding measured RR intervals.
// A pop in the same cycle as a push to a full FIFO frees the slot first.
module hrv_rr_fifo
  import hrv_pkg::*;
#(
  parameter int DEPTH = HRV_FIFO_DEPTH,
  parameter int CNT_W = HRV_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [CNT_W-1:0]           data_i,
  input  logic                       pop_i,
  output logic [CNT_W-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       drop_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_FW = $clog2(DEPTH+1);
  localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(DEPTH);

  logic [CNT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              pop_ok_s;
  logic              push_ok_s;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == {CNT_FW{1'b0}});
  assign count_o = count_q;

  // Accept pops only when data exists; a simultaneous pop makes room for a push.
  always_comb begin
    pop_ok_s  = pop_i & ~empty_o;
    push_ok_s = push_i & (~full_o | pop_ok_s);
    drop_o    = push_i & full_o & ~pop_ok_s;
  end

  // Next-state pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_FW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_FW'(push_ok_s) - CNT_FW'(pop_ok_s);
    end
  end

  // Head of queue shown combinationally; zero when empty.
  always_comb begin
    if (empty_o) begin
      data_o = {CNT_W{1'b0}};
    end else begin
      data_o = mem_q[rd_ptr_q];
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_FW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port; contents are cleared on reset so no stale data leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {CNT_W{1'b0}};
      end
    end else if (push_ok_s && !clr_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/hrv_rr_sequencer.sv
// HRV front end: conditions the raw R-peak input, times beat-to-beat intervals
// in sample ticks, applies refractory/timeout rules and queues intervals.
module hrv_rr_sequencer
  import hrv_pkg::*;
#(
  parameter int CNT_W  = HRV_CNT_W,
  parameter int DEPTH  = HRV_FIFO_DEPTH,
  parameter int MIN_RR = HRV_MIN_RR,
  parameter int MAX_RR = HRV_MAX_RR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       tick,
  input  logic                       beat_in,
  input  logic                       clr,
  output logic [CNT_W-1:0]           rr_data,
  output logic                       rr_valid,
  input  logic                       rr_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic                       timeout,
  output logic [1:0]                 state_o
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_RR);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RR);

  logic             sync1_q, sync2_q, prev_q, pulse_q;
  rr_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cap_s;
  logic             push_s;
  logic             tmo_set_s;
  logic             empty_s;
  logic             full_s;
  logic             drop_s;

  // Two-flop synchronizer plus registered rising-edge detector; clr leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= beat_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign cap_s = cnt_q + CNT_W'(tick);

  // Interval FSM: open on the first beat, push qualifying beats, arm after timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push_s    = 1'b0;
    tmo_set_s = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else if (ena) begin
      case (state_q)
        IDLE, ARMED: begin
          cnt_d = {CNT_W{1'b0}};
          if (pulse_q) begin
            state_d = MEASURE;
          end else begin
            state_d = state_q;
          end
        end
        MEASURE: begin
          if (pulse_q && (cap_s >= MIN_C)) begin
            push_s = 1'b1;
            cnt_d  = {CNT_W{1'b0}};
          end else if (cap_s >= MAX_C) begin
            tmo_set_s = 1'b1;
            state_d   = ARMED;
            cnt_d     = {CNT_W{1'b0}};
          end else begin
            cnt_d = cap_s;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // Sticky status flags, cleared only by clr or reset.
  always_comb begin
    if (clr) begin
      ovf_d = 1'b0;
      tmo_d = 1'b0;
    end else begin
      ovf_d = ovf_q | drop_s;
      tmo_d = tmo_q | tmo_set_s;
    end
  end

  // FSM, counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  hrv_rr_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .push_i  (push_s),
    .data_i  (cap_s),
    .pop_i   (rr_valid & rr_ready),
    .data_o  (rr_data),
    .full_o  (full_s),
    .empty_o (empty_s),
    .drop_o  (drop_s),
    .count_o (fifo_count)
  );

  assign rr_valid = ~empty_s;
  assign overflow = ovf_q;
  assign timeout  = tmo_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_hrv_rr_sequencer.sv
// Self-checking bench: tick-timestamp reference model feeds a scoreboard queue,
// a monitor on the falling edge compares every cycle.
module tb_hrv_rr_sequencer;

  localparam int CNT_W  = 12;
  localparam int DEPTH  = 4;
  localparam int MIN_RR = 250;
  localparam int MAX_RR = 2000;

  logic             clk = 1'b0;
  logic             rst_n, ena, tick, beat_in, clr, rr_ready;
  logic [CNT_W-1:0] rr_data;
  logic             rr_valid, overflow, timeout;
  logic [2:0]       fifo_count;
  logic [1:0]       state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hrv_rr_sequencer #(
    .CNT_W (CNT_W), .DEPTH (DEPTH), .MIN_RR (MIN_RR), .MAX_RR (MAX_RR)
  ) dut (
    .clk (clk), .rst_n (rst_n), .ena (ena), .tick (tick), .beat_in (beat_in),
    .clr (clr), .rr_data (rr_data), .rr_valid (rr_valid), .rr_ready (rr_ready),
    .fifo_count (fifo_count), .overflow (overflow), .timeout (timeout),
    .state_o (state_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Intervals are differences of a running count of enabled ticks.
  int exp_q[$];
  int occ = 0;
  bit m_meas = 0, m_armed = 0, m_ovf = 0, m_tmo = 0;
  int tick_total = 0, open_mark = 0;
  bit hist [5];
  bit m_pulse;
  int m_now, m_iv;
  bit m_push;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        occ = 0; m_meas = 0; m_armed = 0; m_ovf = 0; m_tmo = 0;
        tick_total = 0; open_mark = 0;
        for (int i = 0; i < 5; i++) hist[i] = 0;
      end else begin
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = beat_in;
        // the beat is seen three cycles after the input rises
        m_pulse = hist[3] && !hist[4];
        if (clr) begin
          exp_q.delete();
          occ = 0; m_meas = 0; m_armed = 0; m_ovf = 0; m_tmo = 0;
        end else begin
          if (occ > 0 && rr_ready) occ--;
          m_push = 0;
          m_iv = 0;
          if (ena) begin
            m_now = tick_total + (tick ? 1 : 0);
            if (m_meas) begin
              m_iv = m_now - open_mark;
              if (m_pulse && m_iv >= MIN_RR) begin
                m_push = 1;
                open_mark = m_now;
              end else if (m_iv >= MAX_RR) begin
                m_tmo = 1; m_meas = 0; m_armed = 1;
              end
            end else if (m_pulse) begin
              m_meas = 1; m_armed = 0;
              open_mark = m_now;
            end
            tick_total = m_now;
          end
          if (m_push) begin
            if (occ < DEPTH) begin
              occ++;
              exp_q.push_back(m_iv);
            end else begin
              m_ovf = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("fifo_count", fifo_count, occ);
      chk("rr_valid", rr_valid, (occ > 0) ? 1 : 0);
      chk("overflow", overflow, m_ovf);
      chk("timeout", timeout, m_tmo);
      chk("state_o", state_o, m_meas ? 2 : (m_armed ? 1 : 0));
      if (rr_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: rr_valid=1 with rr_data=%0d but no interval expected", rr_data);
        end else begin
          chk("rr_data", rr_data, exp_q[0]);
          if (rr_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("rr_data_empty", rr_data, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat();
    beat_in = 1'b1;
    step(3);
    beat_in = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; tick = 1'b0; beat_in = 1'b0; clr = 1'b0; rr_ready = 1'b0;
    step(5);
    rst_n = 1'b1;
    step(1);
    chk("rst_valid", rr_valid, 0);
    chk("rst_data", rr_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_state", state_o, 0);

    // two 800-tick intervals
    tick = 1'b1;
    beat(); step(797);
    beat(); step(797);
    beat(); step(5);
    chk("t2_count", fifo_count, 2);
    chk("t2_ovf", overflow, 0);
    chk("t2_head", rr_data, 800);
    rr_ready = 1'b1;
    step(3);
    chk("t2_drained", rr_valid, 0);
    rr_ready = 1'b0;
    pulse_clr();

    // refractory: the 100-tick beat is ignored
    beat(); step(97);
    beat(); step(597);
    beat(); step(5);
    chk("t3_count", fifo_count, 1);
    chk("t3_head", rr_data, 700);
    pulse_clr();

    // timeout exactly MAX_RR ticks after entering MEASURE
    beat(); step(1);
    chk("t4_measure", state_o, 2);
    step(1999);
    chk("t4_pre_state", state_o, 2);
    chk("t4_pre_tmo", timeout, 0);
    step(1);
    chk("t4_tmo", timeout, 1);
    chk("t4_armed", state_o, 1);
    chk("t4_count", fifo_count, 0);
    beat(); step(2);
    chk("t4_rearm_state", state_o, 2);
    chk("t4_rearm_count", fifo_count, 0);
    chk("t4_rearm_tmo", timeout, 1);
    pulse_clr();

    // overflow: six beats 300 apart, nothing drained
    for (int i = 0; i < 6; i++) begin
      beat(); step(297);
    end
    chk("t5_count", fifo_count, 4);
    chk("t5_ovf", overflow, 1);
    chk("t5_head", rr_data, 300);
    rr_ready = 1'b1;
    step(4);
    chk("t5_drained", rr_valid, 0);
    rr_ready = 1'b0;
    pulse_clr();

    // clr with entries queued and timeout set
    beat(); step(2010);
    beat(); step(297);
    beat(); step(297);
    beat(); step(5);
    chk("t6_pre_count", fifo_count, 2);
    chk("t6_pre_tmo", timeout, 1);
    pulse_clr();
    chk("t6_count", fifo_count, 0);
    chk("t6_valid", rr_valid, 0);
    chk("t6_tmo", timeout, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_state", state_o, 0);

    // freeze: 96 ticks, then ena low with a beat, then 204 more ticks
    beat(); step(97);
    ena = 1'b0;
    beat(); step(500);
    chk("t6_frozen_state", state_o, 2);
    chk("t6_frozen_count", fifo_count, 0);
    ena = 1'b1;
    step(200);
    beat(); step(5);
    chk("t6_ena_count", fifo_count, 1);
    chk("t6_ena_head", rr_data, 300);

    // asynchronous reset in the middle of an interval
    rst_n = 1'b0;
    #1;
    chk("arst_valid", rr_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_data", rr_data, 0);
    chk("arst_state", state_o, 0);
    step(3);
    rst_n = 1'b1;
    step(2);

    // randomized traffic against the model
    for (int i = 0; i < 20000; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      ena = ($urandom_range(0, 49) != 0);
      clr = ($urandom_range(0, 3999) == 0);
      if (((i / 3000) % 2) == 1) rr_ready = ($urandom_range(0, 2) != 0);
      else rr_ready = 1'b0;
      if ($urandom_range(0, 299) == 0) beat_in = ~beat_in;
      step(1);
    end
    clr = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hrv_rr_sequencer.md
Name: hrv_rr_sequencer

Overview:
- Front-end controller for the HRV datapath inside tt_um_hrv.
- Detects R-peak beats on a raw input pin and times each beat-to-beat (RR) interval in sample ticks.
- Applies refractory and timeout rules, then queues valid intervals into a small FIFO.
- The downstream HRV compute stage drains the FIFO through a valid/ready handshake.

Parameters:
- CNT_W, 12: width of the RR interval counter and of rr_data.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- MIN_RR, 250: refractory limit in ticks; beats arriving earlier are ignored.
- MAX_RR, 2000: timeout limit in ticks; must be less than 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; low freezes measurement.
- tick  in  1  single-cycle sample strobe (1 kHz nominal).
- beat_in  in  1  raw asynchronous R-peak level.
- clr  in  1  synchronous clear: flush FIFO, clear flags, return to IDLE.
- rr_data  out  CNT_W  interval at FIFO head.
- rr_valid  out  1  FIFO not empty.
- rr_ready  in  1  consumer accepts the head when rr_valid and rr_ready are both high.
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky flag: an interval was dropped because the FIFO was full.
- timeout  out  1  sticky flag: MAX_RR was reached without a beat.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE; counter 0; FIFO empty.
  - rr_valid=0, rr_data=0, fifo_count=0, overflow=0, timeout=0, state_o=IDLE (2'd0).
- Beat input conditioning:
  - beat_in passes through a 2-FF synchronizer, then a registered rising-edge detector.
  - beat_pulse therefore asserts on the 3rd clk edge after beat_in rises and lasts 1 cycle.
  - A held-high beat_in produces exactly one pulse.
- FSM states: IDLE=0, ARMED=1, MEASURE=2. Encoding 3 is unused and recovers to IDLE.
- IDLE:
  - counter held at 0.
  - beat_pulse with ena=1 goes to MEASURE with counter cleared. No push: the first beat only opens an interval.
- MEASURE:
  - On each tick with ena=1, counter increments by 1.
  - Define cap = counter + tick.
  - beat_pulse with cap < MIN_RR: beat ignored, no state change.
  - beat_pulse with cap >= MIN_RR: push cap into the FIFO, counter goes to 0, stay in MEASURE.
  - When cap reaches MAX_RR with no qualifying beat: set timeout, go to ARMED, counter 0, no push.
  - A qualifying beat in the same cycle as reaching MAX_RR is a beat: push MAX_RR, no timeout.
- ARMED:
  - Resynchronisation after a timeout; behaves like IDLE.
  - Next beat_pulse goes to MEASURE with no push; timeout stays set.
- ena=0:
  - Counter, FSM and beat acceptance are frozen; beat_pulse is discarded.
  - The FIFO read side keeps operating.
- FIFO:
  - First-word fall-through: rr_data shows the head combinationally from storage while rr_valid=1. rr_data=0 when empty.
  - Push to a full FIFO: data dropped, overflow set, measurement continues normally.
  - Push and pop in the same cycle when full: the pop frees a slot, so the push succeeds and overflow is not set.
  - Push and pop in the same cycle when empty: the push lands; rr_valid rises next cycle.
  - Push latency: rr_valid and fifo_count update 1 cycle after the pushing beat_pulse cycle.
  - Read/write pointers wrap modulo DEPTH.
- clr:
  - Takes priority over every other event in its cycle.
  - Next state IDLE, FIFO empty, flags 0, counter 0.
  - Synchronizer contents are kept.
- Reset mid-interval: any partial count is lost; no push is generated.

Decomposition:
- Package hrv_pkg holds:
  - state enum type rr_state_t (IDLE, ARMED, MEASURE);
  - default constants HRV_CNT_W=12, HRV_FIFO_DEPTH=4, HRV_MIN_RR=250, HRV_MAX_RR=2000.
- Sub-module hrv_rr_fifo: parameterized DEPTH×CNT_W FIFO with push, pop, full, empty and count, same clk/rst_n.
- The top of the block holds the synchronizer, edge detector, counter and FSM.

Test Plan:
1. Reset with rst_n=0 for 5 cycles, then release -> all outputs 0, state_o=0. Asserting rst_n=0 mid-MEASURE returns every output to 0 asynchronously.
2. tick held high; beats at cycle 10, 10+800, 10+1600; rr_ready=0 -> two entries, each 800; fifo_count=2; overflow=0.
3. tick high; beat, then a second beat 100 ticks later, then a third beat 700 ticks after the first -> the 100-tick beat is ignored; single entry 700.
4. tick high; one beat then silence -> timeout=1 and state_o=ARMED exactly 2000 ticks after MEASURE entry; fifo_count=0. The next beat moves to MEASURE with no push.
5. rr_ready=0; 6 beats spaced 300 ticks -> fifo_count=4 holding 300×4; overflow=1. Then rr_ready=1 -> 4 pops, each reading 300, then rr_valid=0.
6. With 2 entries queued and timeout set, pulse clr -> fifo_count=0, rr_valid=0, flags 0, state_o=IDLE. With ena=0, beats produce no push and the counter is held.
